// File: rtl/simple_sequence_detector.sv
// Serial 10110 detector with overlap; one-cycle registered pulse on detected.
// resetn is active-high and synchronous despite its name.
module simple_sequence_detector (
    input  logic clk,
    input  logic resetn,
    input  logic seq,
    input  logic valid,
    output logic detected
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        S1     = 3'd1,
        S10    = 3'd2,
        S101   = 3'd3,
        S1011  = 3'd4,
        S10110 = 3'd5
    } state_t;

    state_t state;

    always_ff @(posedge clk) begin
        if (resetn) begin
            state    <= IDLE;
            detected <= 1'b0;
        end else begin
            detected <= 1'b0;
            // seq is only looked at under valid, so X on an idle cycle never propagates
            case (state)
                IDLE:   if (valid) state <= seq ? S1    : IDLE;
                S1:     if (valid) state <= seq ? S1    : S10;
                S10:    if (valid) state <= seq ? S101  : IDLE;
                S101:   if (valid) state <= seq ? S1011 : S10;
                S1011:  if (valid) begin
                            state    <= seq ? S1 : S10110;
                            detected <= ~seq;
                        end
                S10110: if (valid) state <= seq ? S101  : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_sequence_detector.sv
// Directed bench for simple_sequence_detector: reset, overlap, gaps, mid-pattern reset.
module tb_simple_sequence_detector;

    logic clk = 1'b0;
    logic resetn;
    logic seq;
    logic valid;
    logic detected;

    int checks   = 0;
    int failures = 0;

    simple_sequence_detector dut (
        .clk      (clk),
        .resetn   (resetn),
        .seq      (seq),
        .valid    (valid),
        .detected (detected)
    );

    always #5 clk = ~clk;

    // One clock: apply inputs, take the edge, check detected 1 time unit later.
    task automatic step(input logic r, input logic v, input logic s, input logic exp,
                        input string tag);
        resetn = r;
        valid  = v;
        seq    = s;
        @(posedge clk);
        #1;
        checks++;
        assert (detected === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, detected, exp);
        end
    endtask

    // n valid bits, first-received bit is bits[n-1]; exp[i] is detected after bits[i].
    task automatic drive(input int n, input logic [15:0] bits, input logic [15:0] exp,
                         input string tag);
        for (int i = n - 1; i >= 0; i--)
            step(1'b0, 1'b1, bits[i], exp[i], $sformatf("%s[%0d]", tag, n - 1 - i));
    endtask

    initial begin
        resetn = 1'b1;
        valid  = 1'b0;
        seq    = 1'b0;

        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, "reset");
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "idle_after_reset");

        // basic pattern
        drive(5, 16'b10110, 16'b00001, "basic");

        // overlap: 10110 then 110 x3 -> 4 pulses
        drive(3, 16'b110, 16'b001, "overlap1");
        drive(3, 16'b110, 16'b001, "overlap2");
        drive(3, 16'b110, 16'b001, "overlap3");

        // 1011 then 1 goes to S1, so only the final 0 completes
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "flush0");
        drive(9, 16'b101110110, 16'b000000001, "s1011_to_s1");

        // mid-pattern reset drops the partial 101; 10 afterwards must not fire
        drive(3, 16'b101, 16'b000, "pre_reset");
        step(1'b1, 1'b1, 1'b1, 1'b0, "mid_reset0");
        step(1'b1, 1'b1, 1'b0, 1'b0, "mid_reset1");
        drive(2, 16'b10, 16'b00, "post_reset");
        drive(5, 16'b10110, 16'b00001, "fresh_after_reset");

        // reset overrides a completing 0 from S1011
        drive(4, 16'b1011, 16'b0000, "pre_override");
        step(1'b1, 1'b1, 1'b0, 1'b0, "reset_override");
        step(1'b0, 1'b1, 1'b0, 1'b0, "after_override");

        // gap with valid low holds state; X on seq is ignored
        drive(4, 16'b1011, 16'b0000, "gap_pre");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "gap_hold");
        step(1'b0, 1'b0, 1'bx, 1'b0, "gap_x");
        step(1'b0, 1'b0, 1'b1, 1'b0, "gap_one");
        step(1'b0, 1'b1, 1'b0, 1'b1, "gap_resume");
        step(1'b0, 1'b0, 1'b0, 1'b0, "pulse_one_cycle");

        // no false hits on runs of ones / zeros
        drive(8, 16'b11111111, 16'b0, "ones");
        drive(8, 16'b00000000, 16'b0, "zeros");
        drive(10, 16'b1011010110, 16'b0000100001, "double");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
